ccd_bayer_to_rgb: RTL and testbench
===================================

# ccd_bayer_to_rgb

Converts the raw 12-bit Bayer pixel stream from the CCD capture stage into RGB pixels for the downstream frame writer. It sits directly after CCD_Capture: it takes the capture stage's data-valid strobe, pixel data and X/Y counters, buffers one sensor line, and emits one RGB pixel per 2x2 Bayer quad, giving half resolution in each axis.

## Interface
- LINE_WIDTH, 1280: maximum sensor pixels per line; sets the depth of the line buffer.
- DATA_W, 12: raw pixel width and the width of each RGB component.
- iclk  in  1  pixel clock; all state is clocked on its rising edge.
- irst  in  1  reset; asynchronous, active-high.
- idata  in  DATA_W  raw Bayer pixel; sampled when idval=1.
- idval  in  1  input pixel valid, driven by the capture stage.
- ix_cont  in  16  column index of idata, starting at 0 on each line.
- iy_cont  in  16  row index of idata, starting at 0 on each frame.
- odval  out  1  one-cycle strobe marking a valid RGB pixel.
- ored  out  DATA_W  red component.
- ogreen  out  DATA_W  green component.
- oblue  out  DATA_W  blue component.
- ox_cont  out  16  output column, equal to ix_cont>>1 of the quad.
- oy_cont  out  16  output row, equal to iy_cont>>1 of the quad.

## Operation
- Bayer layout is fixed GRBG. Even rows carry G R G R…; odd rows carry B G B G….
- Line buffer: LINE_WIDTH x DATA_W, synchronous read, read-before-write at one address.
  - On each accepted pixel (idval=1 and ix_cont<LINE_WIDTH), the block reads buf[ix_cont], which holds the pixel from row y-1, then writes idata to buf[ix_cont].
- Pixels with ix_cont>=LINE_WIDTH are dropped: no buffer write and no output.
- Stage 1 registers the following:
  - the input pixel (cur) and the buffer read data (up);
  - the previous accepted cur and up (cur_d, up_d);
  - a quad flag, set when idval=1, ix_cont[0]=1 and iy_cont[0]=1;
  - ix_cont and iy_cont.
- Stage 2 fires on quad flag = 1, with G0=up_d, R=up, B=cur_d and G1=cur:
  - ored=R;
  - oblue=B;
  - ogreen is as set in Configuration;
  - ox_cont=x>>1 and oy_cont=y>>1;
  - odval=1.
- The horizontal history (cur_d, up_d) updates only on accepted pixels. Gaps in idval within a line therefore do not corrupt quads.
- Even rows and even columns never produce output.
- Row 1 of the first frame after reset reads whatever the buffer holds from row 0. The buffer is never cleared, and this row needs no clearing because row 0 always precedes it.
- Reset mid-operation clears all pipeline registers and outputs. The first quad after reset is valid only once a full even row has been written.

## Timing
- Reset values: odval=0; ored, ogreen, oblue, ox_cont and oy_cont all 0; all pipeline registers 0.
- Latency: odval asserts exactly 2 cycles after the idval cycle carrying the odd/odd pixel.
- RGB and coordinate outputs are registered. They hold their values until the next odval and are valid only while odval=1.
- Throughput: one input pixel per cycle, sustained. There is no backpressure, so the consumer must accept every odval pulse.
- Output rate: at most one odval per 2 input cycles, at most one per 4 over a frame.
- Back-to-back lines (ix_cont wraps to 0 on the next cycle) need no idle cycle.

## Configuration
- CCD_RGB_GREEN_AVG_EN defined: ogreen = (G0+G1)>>1.
  - The sum is DATA_W+1 bits, so it cannot overflow.
  - The shift truncates toward zero.
- Macro undefined: ogreen=G1. The adder is removed and all other behaviour is identical.

## Structure
- Shared package ccd_pkg holds the following:
  - DATA_W default;
  - COORD_W=16;
  - typedef rgb_t (three DATA_W fields);
  - Bayer phase constants for GRBG.
- Sub-module ccd_line_buffer (parameters DEPTH and WIDTH) is a single-port, read-before-write synchronous RAM. It must infer block RAM, and there is no reset on its contents.

## Test plan
- Single 4x2 frame, row0 = 100,200,101,201 and row1 = 300,400,301,401 → 2 odval pulses:
  - first pulse: R=200, B=300, G=250 (with the macro) or G=400 (without), ox=0, oy=0;
  - second pulse: R=201, B=301, G=251 or 401, ox=1.
- Latency check: the odval rising edge occurs exactly 2 cycles after idval with ix_cont=1 and iy_cont=1.
- idval gaps of 3 idle cycles between every pixel of the same 4x2 frame → identical RGB values; no odval during even rows.
- ix_cont=LINE_WIDTH and LINE_WIDTH+1 with idval=1 → no odval; buf[0..LINE_WIDTH-1] unchanged, verified by the next quad outputs.
- Full-scale inputs of 4095 for all pixels → ogreen=4095, no wrap.
- irst pulsed mid row 1 → all outputs 0 asynchronously. After release, a new frame produces correct quads starting from its row 1.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD Bayer-to-RGB path: widths, RGB pixel type and
// GRBG phase constants.
package ccd_pkg;

    localparam int CCD_DATA_W = 12;
    localparam int COORD_W    = 16;

    typedef struct packed {
        logic [CCD_DATA_W-1:0] red;
        logic [CCD_DATA_W-1:0] green;
        logic [CCD_DATA_W-1:0] blue;
    } rgb_t;

    // Phase encoding is {row[0], col[0]}; GRBG puts green at even/even and odd/odd.
    typedef enum logic [1:0] {
        PH_G0 = 2'b00,
        PH_R  = 2'b01,
        PH_B  = 2'b10,
        PH_G1 = 2'b11
    } bayer_phase_t;

    function automatic bayer_phase_t bayer_phase(input logic x0, input logic y0);
        return bayer_phase_t'({y0, x0});
    endfunction

endpackage

// File: rtl/ccd_line_buffer.sv
// Single-port line buffer: registered read of the old word, then write of the
// new word at the same address. Contents are never reset.
module ccd_line_buffer #(
    parameter int  DEPTH = 1280,
    parameter int  WIDTH = 12,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/ccd_bayer_to_rgb.sv
// GRBG Bayer to half-resolution RGB: one RGB pixel per 2x2 quad, emitted two
// cycles after the odd/odd pixel. Define CCD_RGB_GREEN_AVG_EN to average the greens.
module ccd_bayer_to_rgb
    import ccd_pkg::*;
#(
    parameter int LINE_WIDTH = 1280,
    parameter int DATA_W     = CCD_DATA_W
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [DATA_W-1:0]  idata,
    input  logic               idval,
    input  logic [COORD_W-1:0] ix_cont,
    input  logic [COORD_W-1:0] iy_cont,
    output logic               odval,
    output logic [DATA_W-1:0]  ored,
    output logic [DATA_W-1:0]  ogreen,
    output logic [DATA_W-1:0]  oblue,
    output logic [COORD_W-1:0] ox_cont,
    output logic [COORD_W-1:0] oy_cont
);

    localparam int                 AW      = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(LINE_WIDTH);

    logic                accept;
    logic [DATA_W-1:0]   up;
    logic [DATA_W-1:0]   cur;
    logic [DATA_W-1:0]   cur_d;
    logic [DATA_W-1:0]   up_d;
    logic                quad;
    logic [COORD_W-2:0]  x_half;
    logic [COORD_W-2:0]  y_half;
    logic [DATA_W-1:0]   green;

    // Out-of-range columns must neither touch the buffer nor the history.
    assign accept = idval && (ix_cont < X_LIMIT);

    ccd_line_buffer #(
        .DEPTH (LINE_WIDTH),
        .WIDTH (DATA_W)
    ) u_line_buffer (
        .clk   (iclk),
        .en    (accept),
        .addr  (ix_cont[AW-1:0]),
        .wdata (idata),
        .rdata (up)
    );

`ifdef CCD_RGB_GREEN_AVG_EN
    logic [DATA_W:0] green_sum;
    assign green_sum = {1'b0, up_d} + {1'b0, cur};
    assign green     = green_sum[DATA_W:1];
`else
    assign green = cur;
`endif

    // Stage 1: the buffer's read register holds "up"; history moves only on accepted pixels.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            cur    <= '0;
            cur_d  <= '0;
            up_d   <= '0;
            quad   <= 1'b0;
            x_half <= '0;
            y_half <= '0;
        end else begin
            quad <= accept && (bayer_phase(ix_cont[0], iy_cont[0]) == PH_G1);
            if (accept) begin
                cur    <= idata;
                cur_d  <= cur;
                up_d   <= up;
                x_half <= ix_cont[COORD_W-1:1];
                y_half <= iy_cont[COORD_W-1:1];
            end
        end
    end

    // Stage 2: quad is G0=up_d, R=up, B=cur_d, G1=cur; outputs hold between pulses.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            odval   <= 1'b0;
            ored    <= '0;
            ogreen  <= '0;
            oblue   <= '0;
            ox_cont <= '0;
            oy_cont <= '0;
        end else begin
            odval <= quad;
            if (quad) begin
                ored    <= up;
                oblue   <= cur_d;
                ogreen  <= green;
                ox_cont <= {1'b0, x_half};
                oy_cont <= {1'b0, y_half};
            end
        end
    end

endmodule

// File: tb/tb_ccd_bayer_to_rgb.sv
// Randomized bench for ccd_bayer_to_rgb: expected quads come straight from the
// frame array being sent; checked with exact output cycle.
module tb_ccd_bayer_to_rgb;

    localparam int LW = 16;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic [11:0] idata = '0;
    logic        idval = 1'b0;
    logic [15:0] ix_cont = '0;
    logic [15:0] iy_cont = '0;
    logic        odval;
    logic [11:0] ored, ogreen, oblue;
    logic [15:0] ox_cont, oy_cont;

    ccd_bayer_to_rgb #(.LINE_WIDTH(LW), .DATA_W(12)) dut (
        .iclk    (iclk),
        .irst    (irst),
        .idata   (idata),
        .idval   (idval),
        .ix_cont (ix_cont),
        .iy_cont (iy_cont),
        .odval   (odval),
        .ored    (ored),
        .ogreen  (ogreen),
        .oblue   (oblue),
        .ox_cont (ox_cont),
        .oy_cont (oy_cont)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    typedef struct {
        int r;
        int g;
        int b;
        int ox;
        int oy;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   frm[4][16];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    // One input cycle; an accepted odd/odd pixel queues the quad it completes.
    task automatic drive(input int x, input int y, input int d, input bit v);
        exp_t e;
        int   g0, g1;
        @(posedge iclk);
        #1;
        idval   = v;
        ix_cont = 16'(x);
        iy_cont = 16'(y);
        idata   = 12'(d);
        if (v && x < LW && (x % 2) == 1 && (y % 2) == 1) begin
            g0   = frm[y-1][x-1];
            g1   = frm[y][x];
            e.r  = frm[y-1][x];
            e.b  = frm[y][x-1];
`ifdef CCD_RGB_GREEN_AVG_EN
            e.g  = (g0 + g1) / 2;
`else
            e.g  = g1 + 0 * g0;
`endif
            e.ox = x / 2;
            e.oy = y / 2;
            e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive($urandom_range(0, LW-1), $urandom_range(0, 3), $urandom_range(0, 4095), 1'b0);
    endtask

    task automatic fill_frame(input int w, input int h, input int lo, input int hi);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                frm[y][x] = $urandom_range(lo, hi);
    endtask

    task automatic send_frame(input int w, input int h, input int gmin, input int gmax, input bit oob);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                drive(x, y, frm[y][x], 1'b1);
                idle($urandom_range(gmin, gmax));
                if (oob && (x % 2) == 0) begin
                    drive(LW, y, $urandom_range(0, 4095), 1'b1);
                    drive(LW + 1, y, $urandom_range(0, 4095), 1'b1);
                end
            end
        end
    endtask

    // Monitor: odval must pulse exactly at each queued cycle and nowhere else.
    always @(negedge iclk) begin
        exp_t e;
        if (!irst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("odval", int'(odval), 1);
                check("ored", int'(ored), e.r);
                check("ogreen", int'(ogreen), e.g);
                check("oblue", int'(oblue), e.b);
                check("ox_cont", int'(ox_cont), e.ox);
                check("oy_cont", int'(oy_cont), e.oy);
            end else begin
                check("idle_odval", int'(odval), 0);
            end
        end
    end

    initial begin
        irst = 1'b1;
        repeat (2) @(posedge iclk);
        #1;
        check("rst_odval", int'(odval), 0);
        check("rst_ored", int'(ored), 0);
        check("rst_ogreen", int'(ogreen), 0);
        check("rst_oblue", int'(oblue), 0);
        check("rst_ox", int'(ox_cont), 0);
        check("rst_oy", int'(oy_cont), 0);
        irst = 1'b0;

        // Directed 4x2 frame, back-to-back then with 3-cycle gaps.
        frm[0][0] = 100; frm[0][1] = 200; frm[0][2] = 101; frm[0][3] = 201;
        frm[1][0] = 300; frm[1][1] = 400; frm[1][2] = 301; frm[1][3] = 401;
        send_frame(4, 2, 0, 0, 1'b0);
        idle(4);
        send_frame(4, 2, 3, 3, 1'b0);
        idle(4);

        // Out-of-range columns interleaved inside rows.
        fill_frame(8, 2, 0, 4095);
        send_frame(8, 2, 0, 0, 1'b1);

        // Full-scale pixels.
        fill_frame(16, 2, 4095, 4095);
        send_frame(16, 2, 0, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int w, h;
            w = 2 * $urandom_range(1, 8);
            h = 2 * $urandom_range(1, 2);
            fill_frame(w, h, 0, 4095);
            send_frame(w, h, 0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        idle(3);

        // Reset pulsed mid row 1, after the first quad has been output.
        fill_frame(8, 2, 1, 4095);
        for (int x = 0; x < 8; x++) drive(x, 0, frm[0][x], 1'b1);
        for (int x = 0; x < 6; x++) drive(x, 1, frm[1][x], 1'b1);
        #2;
        irst = 1'b1;
        #1;
        check("arst_odval", int'(odval), 0);
        check("arst_ored", int'(ored), 0);
        check("arst_ogreen", int'(ogreen), 0);
        check("arst_oblue", int'(oblue), 0);
        check("arst_ox", int'(ox_cont), 0);
        check("arst_oy", int'(oy_cont), 0);
        exp_q.delete();
        idval = 1'b0;
        @(posedge iclk);
        #3;
        irst = 1'b0;
        fill_frame(8, 4, 0, 4095);
        send_frame(8, 4, 0, 1, 1'b0);

        idle(5);
        check("missing_odval", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
